// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALU operation codes, opcode/function encodings,
// instruction field positions, decoded-control and output-slot types, extension helpers.
package mips_pkg;

    // ALU operation codes understood by the execute stage
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Instruction field bit positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Control fields produced by the combinational decoder
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        sel_imm;
        logic        reg_write;
        logic [4:0]  dest;
        logic        illegal;
        logic [26:0] imm;
        logic [26:0] pc_inc;
    } dec_ctrl_t;

    // Contents of the registered output slot
    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] pc;
        dec_ctrl_t   ctrl;
    } slot_t;

    function automatic logic [26:0] sext16_27(input logic [15:0] v);
        return {{11{v[15]}}, v};
    endfunction

    function automatic logic [26:0] zext16_27(input logic [15:0] v);
        return {11'd0, v};
    endfunction

    // Branch offset: word offset scaled to bytes, sign-extended to 27 bits
    function automatic logic [26:0] branch_off27(input logic [15:0] v);
        return {{9{v[15]}}, v, 2'b00};
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: two combinational read ports with write-first bypass,
// one synchronous write port, r0 hardwired to zero, synchronous clear.
module decode_stage_regfile #(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [31:0]   rdata_a_o,
    output logic [31:0]   rdata_b_o
);

    logic [31:0] regs_q [NREGS];

    // Storage update: clear everything on reset, otherwise write any register except r0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && (waddr_i != AW'(0))) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read port A: r0 reads zero, a same-cycle write to the source is forwarded
    always_comb begin
        if (raddr_a_i == AW'(0)) begin
            rdata_a_o = 32'd0;
        end else if (we_i && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end else begin
            rdata_a_o = regs_q[raddr_a_i];
        end
    end

    // Read port B: same rules as port A
    always_comb begin
        if (raddr_b_i == AW'(0)) begin
            rdata_b_o = 32'd0;
        end else if (we_i && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end else begin
            rdata_b_o = regs_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage: splits the MIPS word, reads operands, builds the
// immediate and PC delta, and presents the result in a single valid/ready output slot.
module decode_stage
    import mips_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int PC_STEP = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] program_counter_in,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        dec_valid,
    input  logic        ex_ready,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [26:0] immediate,
    output logic [26:0] pc_increment_jump,
    output logic [3:0]  alu_opcode,
    output logic        select_immediate,
    output logic [31:0] program_counter,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        illegal_instr
);

    logic [5:0]  op_s;
    logic [5:0]  fn_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [15:0] imm16_s;
    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;
    logic        accept_s;
    dec_ctrl_t   ctrl_s;
    slot_t       slot_q;
    slot_t       slot_d;
    logic        valid_q;
    logic        valid_d;

    assign op_s    = instruction[OP_HI:OP_LO];
    assign fn_s    = instruction[FN_HI:FN_LO];
    assign rs_s    = instruction[RS_HI:RS_LO];
    assign rt_s    = instruction[RT_HI:RT_LO];
    assign rd_s    = instruction[RD_HI:RD_LO];
    assign imm16_s = instruction[IMM_HI:IMM_LO];

    decode_stage_regfile #(.NREGS(NREGS)) u_regfile (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_s),
        .raddr_b_i (rt_s),
        .rdata_a_o (rs_val_s),
        .rdata_b_o (rt_val_s)
    );

    // Instruction decoder: control fields, immediate and PC delta from the raw word
    always_comb begin
        ctrl_s           = '0;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.sel_imm   = 1'b0;
        ctrl_s.reg_write = 1'b0;
        ctrl_s.dest      = 5'd0;
        ctrl_s.illegal   = 1'b0;
        ctrl_s.imm       = 27'd0;
        ctrl_s.pc_inc    = 27'(PC_STEP);
        case (op_s)
            OP_RTYPE: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.dest      = rd_s;
                case (fn_s)
                    FN_ADD: ctrl_s.alu_op = ALU_ADD;
                    FN_SUB: ctrl_s.alu_op = ALU_SUB;
                    FN_AND: ctrl_s.alu_op = ALU_AND;
                    FN_OR:  ctrl_s.alu_op = ALU_OR;
                    FN_XOR: ctrl_s.alu_op = ALU_XOR;
                    FN_NOR: ctrl_s.alu_op = ALU_NOR;
                    FN_SLT: ctrl_s.alu_op = ALU_SLT;
                    FN_SLL: ctrl_s.alu_op = ALU_SLL;
                    FN_SRL: ctrl_s.alu_op = ALU_SRL;
                    default: begin
                        // Unknown function: flow through as a NOP
                        ctrl_s.illegal   = 1'b1;
                        ctrl_s.reg_write = 1'b0;
                        ctrl_s.dest      = 5'd0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                ctrl_s.alu_op    = (op_s == OP_ADDI) ? ALU_ADD : ALU_SLT;
                ctrl_s.sel_imm   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.dest      = rt_s;
                ctrl_s.imm       = sext16_27(imm16_s);
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                case (op_s)
                    OP_ANDI: ctrl_s.alu_op = ALU_AND;
                    OP_ORI:  ctrl_s.alu_op = ALU_OR;
                    OP_XORI: ctrl_s.alu_op = ALU_XOR;
                    default: ctrl_s.alu_op = ALU_LUI;
                endcase
                ctrl_s.sel_imm   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.dest      = rt_s;
                // LUI also carries the raw imm16; the ALU does the shift
                ctrl_s.imm       = zext16_27(imm16_s);
            end
            OP_BEQ, OP_BNE: begin
                ctrl_s.alu_op = ALU_SUB;
                ctrl_s.imm    = sext16_27(imm16_s);
                ctrl_s.pc_inc = branch_off27(imm16_s);
            end
            OP_J: begin
                ctrl_s.alu_op = ALU_ADD;
                ctrl_s.pc_inc = {instruction[24:0], 2'b00};
            end
            default: begin
                ctrl_s.illegal = 1'b1;
            end
        endcase
    end

    assign instr_ready = ~valid_q | ex_ready;
    assign accept_s    = instr_valid & instr_ready & ~flush;

    // Slot next state: flush kills, accept loads, consume empties, otherwise hold with operand refresh
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d      = 1'b1;
            slot_d.op_a  = rs_val_s;
            slot_d.op_b  = rt_val_s;
            slot_d.rs    = rs_s;
            slot_d.rt    = rt_s;
            slot_d.pc    = program_counter_in;
            slot_d.ctrl  = ctrl_s;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end else begin
            // Stalled: a writeback to a held source must not be lost
            if (valid_q && wb_en && (wb_addr == slot_q.rs) && (slot_q.rs != 5'd0)) begin
                slot_d.op_a = wb_data;
            end else begin
                slot_d.op_a = slot_q.op_a;
            end
            if (valid_q && wb_en && (wb_addr == slot_q.rt) && (slot_q.rt != 5'd0)) begin
                slot_d.op_b = wb_data;
            end else begin
                slot_d.op_b = slot_q.op_b;
            end
        end
    end

    // Output slot register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign dec_valid         = valid_q;
    assign alu_A             = slot_q.op_a;
    assign alu_B             = slot_q.op_b;
    assign immediate         = slot_q.ctrl.imm;
    assign pc_increment_jump = slot_q.ctrl.pc_inc;
    assign alu_opcode        = slot_q.ctrl.alu_op;
    assign select_immediate  = slot_q.ctrl.sel_imm;
    assign program_counter   = slot_q.pc;
    assign dest_reg          = slot_q.ctrl.dest;
    assign reg_write         = slot_q.ctrl.reg_write;
    assign illegal_instr     = slot_q.ctrl.illegal;

endmodule
